// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state type, adjust constants and the digit-count helper.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Decimal digits needed to show 2^width-1 (at least one).
    function automatic int min_digits(input int width);
        logic [63:0] v;
        int          d;
        v = (64'd1 << width) - 64'd1;
        d = 1;
        for (int i = 0; i < 20; i++) begin
            v = v / 64'd10;
            if (v != 64'd0) begin
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble adjust for one BCD nibble: adds 3 when the digit is >= 5.
// Ports: d = scratch nibble in, q = adjusted nibble out (4-bit wrap, no carry).
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ_ADD : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (double dabble).
// Ports: clk, rst (sync, active-high), start, bin -> busy, done pulse, bcd.
// Optional macro BIN2BCD_AUTO_TRIG_EN: also start when bin differs from
// the value of the last accepted conversion.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
        $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t           state_q, state_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic [BW-1:0]    scr_q, scr_n, scr_adj;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [BW-1:0]    bcd_n;
    logic             done_n;
    logic             go;

`ifdef BIN2BCD_AUTO_TRIG_EN
    logic [WIDTH-1:0] last_q, last_n;
    assign go = start || (bin != last_q);
`else
    assign go = start;
`endif

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scr_q[4*k +: 4]),
            .q (scr_adj[4*k +: 4])
        );
    end

    assign busy = (state_q == SHIFT);

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        scr_n   = scr_q;
        cnt_n   = cnt_q;
        bcd_n   = bcd;
        done_n  = 1'b0;
`ifdef BIN2BCD_AUTO_TRIG_EN
        last_n  = last_q;
`endif
        unique case (1'b1)
            (state_q == IDLE): begin
                if (go) begin
                    shift_n = bin;
                    scr_n   = '0;
                    cnt_n   = CNT_LOAD;
                    state_n = SHIFT;
`ifdef BIN2BCD_AUTO_TRIG_EN
                    last_n  = bin;
`endif
                end
            end
            (state_q == SHIFT): begin
                {scr_n, shift_n} = {scr_adj, shift_q} << 1;
                cnt_n = cnt_q - CNT_ONE;
                // Final shift: publish the whole result at once.
                if (cnt_q == CNT_ONE) begin
                    bcd_n   = scr_n;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd     <= '0;
            done    <= 1'b0;
`ifdef BIN2BCD_AUTO_TRIG_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            scr_q   <= scr_n;
            cnt_q   <= cnt_n;
            bcd     <= bcd_n;
            done    <= done_n;
`ifdef BIN2BCD_AUTO_TRIG_EN
            last_q  <= last_n;
`endif
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal arithmetic model.
// Default build; the auto-trigger scenario adapts to BIN2BCD_AUTO_TRIG_EN.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_AUTO_TRIG_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one conversion and watches 16 cycles from the accept edge.
    // With noisy=1, start and bin are scrambled while the DUT is busy.
    task automatic run_conv(input logic [7:0] v, input bit noisy,
                            output int done_at, output int busy_cnt,
                            output int done_cnt);
        bin = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_at = -1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (noisy && k < 7) begin
                start = 1'($urandom);
                bin = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bin = 8'd0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b bcd=%h want 0 0 000",
                     busy, done, bcd);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int vals[4] = '{0, 99, 100, 255};
        int da, bc, dc;
        foreach (vals[i]) begin
            run_conv(8'(vals[i]), 1'b0, da, bc, dc);
            checks++;
            if (da != 8) begin
                errors++;
                $display("FAIL basic_latency bin=%0d: done at %0d want 8",
                         vals[i], da);
            end
            checks++;
            if (bc != 8) begin
                errors++;
                $display("FAIL basic_busy bin=%0d: busy %0d cycles want 8",
                         vals[i], bc);
            end
            checks++;
            if (dc != 1) begin
                errors++;
                $display("FAIL basic_done_cnt bin=%0d: got %0d want 1",
                         vals[i], dc);
            end
            checks++;
            if (bcd !== ref_bcd(vals[i])) begin
                errors++;
                $display("FAIL basic_bcd bin=%0d: got %h want %h",
                         vals[i], bcd, ref_bcd(vals[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bin = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cyc = 0;
            while (!done && cyc < 20) begin
                tick();
                cyc++;
            end
            checks++;
            if (cyc != 8) begin
                errors++;
                $display("FAIL b2b_timing bin=%0d: done after %0d want 8",
                         i, cyc);
            end
            checks++;
            if (bcd !== ref_bcd(i)) begin
                errors++;
                $display("FAIL b2b_bcd bin=%0d: got %h want %h",
                         i, bcd, ref_bcd(i));
            end
            if (i < 255) begin
                bin = 8'(i + 1);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_ignore_busy();
        int dc;
        bin = 8'd37;
        start = 1'b1;
        tick();
        start = 1'b0;
        dc = 0;
        for (int k = 0; k < 24; k++) begin
            if (done) dc++;
            start = (k == 2 || k == 5 || k == 6) ? 1'b1 : 1'b0;
            if (k == 2) bin = 8'd200;
            tick();
        end
        checks++;
        if (dc != 1) begin
            errors++;
            $display("FAIL ignore_done_cnt: got %0d want 1", dc);
        end
        checks++;
        if (bcd !== 12'h037) begin
            errors++;
            $display("FAIL ignore_bcd: got %h want 037", bcd);
        end
    endtask

    task automatic test_random();
        int da, bc, dc, v;
        for (int n = 0; n < 40; n++) begin
            v = int'($urandom_range(0, 255));
            run_conv(8'(v), 1'b1, da, bc, dc);
            checks++;
            if (da != 8 || bc != 8 || dc != 1) begin
                errors++;
                $display("FAIL rand_timing bin=%0d: done_at=%0d busy=%0d dones=%0d want 8 8 1",
                         v, da, bc, dc);
            end
            checks++;
            if (bcd !== ref_bcd(v)) begin
                errors++;
                $display("FAIL rand_bcd bin=%0d: got %h want %h",
                         v, bcd, ref_bcd(v));
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end
    endtask

    task automatic test_abort();
        int da, bc, dc;
        run_conv(8'd180, 1'b0, da, bc, dc);
        dc = 0;
        bin = 8'd255;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (done) dc++;
            tick();
        end
        rst = 1'b1;
        tick();
        if (done) dc++;
        checks++;
        if (busy !== 1'b0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL abort_state: busy=%b bcd=%h want 0 000", busy, bcd);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) dc++;
        end
        checks++;
        if (dc != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d dones want 0", dc);
        end
        run_conv(8'd12, 1'b0, da, bc, dc);
        checks++;
        if (da != 8 || bcd !== 12'h012) begin
            errors++;
            $display("FAIL abort_restart: done_at=%0d bcd=%h want 8 012",
                     da, bcd);
        end
    endtask

    task automatic test_rst_start();
        rst = 1'b1;
        start = 1'b1;
        bin = 8'd77;
        tick();
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_busy: got %b want 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_idle: busy=%b done=%b want 0 0",
                     busy, done);
        end
    endtask

    task automatic test_auto_trig();
        int steps[4] = '{0, 5, 5, 250};
        logic [11:0] expq[$];
        logic [11:0] want;
        int last, dc;
        rst = 1'b1;
        start = 1'b0;
        bin = 8'd0;
        tick();
        rst = 1'b0;
        last = 0;
        dc = 0;
        foreach (steps[s]) begin
            if (AUTO && steps[s] != last) begin
                last = steps[s];
                expq.push_back(ref_bcd(steps[s]));
            end
        end
        foreach (steps[s]) begin
            bin = 8'(steps[s]);
            for (int k = 0; k < 12; k++) begin
                tick();
                if (done) begin
                    dc++;
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL auto_extra_done: bcd=%h", bcd);
                    end else begin
                        want = expq.pop_front();
                        if (bcd !== want) begin
                            errors++;
                            $display("FAIL auto_bcd: got %h want %h",
                                     bcd, want);
                        end
                    end
                end
            end
        end
        checks++;
        if (dc != (AUTO ? 2 : 0)) begin
            errors++;
            $display("FAIL auto_done_cnt: got %0d want %0d",
                     dc, AUTO ? 2 : 0);
        end
        checks++;
        if (bcd !== (AUTO ? 12'h250 : 12'h000)) begin
            errors++;
            $display("FAIL auto_final_bcd: got %h want %h",
                     bcd, AUTO ? 12'h250 : 12'h000);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bin = 8'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_busy();
        test_random();
        test_abort();
        test_rst_start();
        test_auto_trig();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3).
- Sits between the 8-bit counter result and the per-digit 7-segment decoders.
- Lets the hex displays show decimal 000..255 instead of raw hex nibbles.
- One bit is processed per clock; a start/busy/done handshake frames each conversion.

Parameters:
WIDTH, 8, binary input width in bits.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1, checked at elaboration (fatal if violated).

Ports:
clk    input   1           system clock, all logic on rising edge
rst    input   1           synchronous reset, active-high
start  input   1           conversion request, sampled only in IDLE
bin    input   WIDTH       binary value, captured on the accepted start edge
busy   output  1           high while a conversion is in progress
done   output  1           one-cycle pulse: bcd has just been updated
bcd    output  4*DIGITS    result; digit k in bits [4k+3:4k], k=0 is the ones digit

Behaviour:
- Decided interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bcd=0, internal shift/scratch/counter=0.
- States:
  - IDLE: on start=1 at edge N → capture bin into shift reg, clear BCD scratch, load bit counter=WIDTH, go SHIFT. Otherwise stay.
  - SHIFT: each edge applies the adjust step to every scratch digit, then shifts {scratch, shift reg} left by 1 and decrements the counter.
- Adjust step: each scratch nibble >= 5 gets +3. Nibble arithmetic is 4-bit; no carry between nibbles.
- Last shift (counter 1→0) at edge N+WIDTH:
  - load the post-shift scratch into bcd;
  - set done=1 for exactly one cycle;
  - return to IDLE.
- busy = 1 in every cycle where state=SHIFT (cycles after edges N .. N+WIDTH-1); 0 otherwise, including the done cycle.
- Latency: start sampled at edge N → bcd valid and done=1 after edge N+WIDTH (8 cycles at default).
- Back-to-back: start may be high during the done cycle and is accepted at edge N+WIDTH+1. Minimum period is WIDTH+1 cycles.
- start while busy: ignored, not queued. bin changes while busy have no effect (value already captured).
- bcd holds the last result until the next completion. It never shows partial values.
- Reset mid-conversion: abort next edge with no done pulse; bcd returns to 0.
- rst and start asserted together: rst wins.
- Boundaries:
  - bin=0 → bcd all zero digits.
  - bin=2^WIDTH-1 → max decimal (255 → 0x255).
  - No overflow is possible given the DIGITS check.

Optional Feature:
Macro BIN2BCD_AUTO_TRIG_EN.
- Defined:
  - An internal register holds the bin value of the last accepted conversion (reset 0).
  - In IDLE, a conversion also starts when bin differs from that register, even if start=0; the register updates on acceptance.
  - A conversion pending on entry to IDLE starts at the next edge.
  - The display tracks the counter with no external start logic.
- Not defined: conversions start only on explicit start. The extra register and comparator are absent.

Decomposition:
- Package bin2bcd_pkg holds:
  - state typedef (IDLE, SHIFT);
  - constants BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3;
  - a helper function computing the minimum DIGITS for a given WIDTH, used by the elaboration check.
- One combinational sub-module, bcd_digit_adj: 4-bit in, 4-bit out, adds 3 when input >= 5. Instantiated DIGITS times via generate.

Test Plan:
1. start with bin=0, 99, 100, 255 (separate runs) → done after exactly 8 cycles; bcd=0x000, 0x099, 0x100, 0x255; busy high for exactly 8 cycles each.
2. Exhaustive sweep bin=0..255, back-to-back starts timed in each done cycle → every bcd matches the decimal reference model; period 9 cycles; no missed or extra done.
3. start at bin=37, then start pulses and bin=200 during busy → single done, bcd=0x037, no second conversion.
4. start at bin=255, rst=1 at shift cycle 4 → no done, busy=0 and bcd=0 after that edge. Then start at bin=12 → bcd=0x012 after 8 cycles.
5. rst and start both high at the same edge → stays IDLE, busy=0.
6. With BIN2BCD_AUTO_TRIG_EN: start tied 0, bin steps 0→5→5→250 → exactly two conversions (bcd=0x005, then 0x250). Without the macro: no done ever.
